// File: rtl/rv_id_ex_stage.sv
// ID/EX pipeline register for the RV64 core: decodes ALU op select, picks operand 2,
// and optionally forwards from EX/MEM and MEM/WB when RV_IDEX_FWD_EN is defined.
module rv_id_ex_stage #(
  parameter int XLEN = 64
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            valid_i,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [6:0]      opcode_i,
  input  logic [2:0]      funct3_i,
  input  logic            funct7_5_i,
  input  logic [4:0]      rs1_i,
  input  logic [4:0]      rs2_i,
  input  logic [4:0]      rd_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic            exm_wen_i,
  input  logic [4:0]      exm_rd_i,
  input  logic [XLEN-1:0] exm_data_i,
  input  logic            wb_wen_i,
  input  logic [4:0]      wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  output logic            valid_o,
  output logic [XLEN-1:0] op1_o,
  output logic [XLEN-1:0] op2_o,
  output logic [3:0]      op_sel_o,
  output logic [XLEN-1:0] store_data_o,
  output logic [XLEN-1:0] pc_o,
  output logic [4:0]      rd_o,
  output logic            reg_wen_o,
  output logic            mem_ren_o,
  output logic            mem_wen_o,
  output logic            branch_o,
  output logic            illegal_o
);

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_PASS = 4'b1111;

  // Decode
  logic [3:0] dec_op_sel;
  logic       dec_use_imm, dec_zero_op1, dec_reg_wen, dec_mem_ren;
  logic       dec_mem_wen, dec_branch, dec_illegal;

  always_comb begin
    dec_op_sel   = ALU_PASS;
    dec_use_imm  = 1'b0;
    dec_zero_op1 = 1'b0;
    dec_reg_wen  = 1'b0;
    dec_mem_ren  = 1'b0;
    dec_mem_wen  = 1'b0;
    dec_branch   = 1'b0;
    dec_illegal  = 1'b0;
    case (opcode_i)
      7'b0110011, 7'b0010011: begin
        dec_use_imm = (opcode_i == 7'b0010011);
        dec_reg_wen = 1'b1;
        case (funct3_i)
          3'b000: dec_op_sel = (funct7_5_i && !dec_use_imm) ? ALU_SUB : ALU_ADD;
          3'b111: dec_op_sel = ALU_AND;
          3'b110: dec_op_sel = ALU_OR;
          default: begin
            dec_reg_wen = 1'b0;
            dec_illegal = 1'b1;
          end
        endcase
      end
      7'b0000011: begin
        dec_op_sel  = ALU_ADD;
        dec_use_imm = 1'b1;
        dec_mem_ren = 1'b1;
        dec_reg_wen = 1'b1;
      end
      7'b0100011: begin
        dec_op_sel  = ALU_ADD;
        dec_use_imm = 1'b1;
        dec_mem_wen = 1'b1;
      end
      7'b1100011: begin
        if (funct3_i == 3'b000) begin
          dec_op_sel = ALU_SUB;
          dec_branch = 1'b1;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      7'b0110111: begin
        dec_op_sel   = ALU_ADD;
        dec_use_imm  = 1'b1;
        dec_zero_op1 = 1'b1;
        dec_reg_wen  = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // Operand sourcing; EX/MEM beats MEM/WB, x0 is never forwarded
  logic [XLEN-1:0] rs1_val, rs2_val;
`ifdef RV_IDEX_FWD_EN
  always_comb begin
    rs1_val = rs1_data_i;
    if (exm_wen_i && (exm_rd_i == rs1_i) && (rs1_i != 5'd0))
      rs1_val = exm_data_i;
    else if (wb_wen_i && (wb_rd_i == rs1_i) && (rs1_i != 5'd0))
      rs1_val = wb_data_i;
    rs2_val = rs2_data_i;
    if (exm_wen_i && (exm_rd_i == rs2_i) && (rs2_i != 5'd0))
      rs2_val = exm_data_i;
    else if (wb_wen_i && (wb_rd_i == rs2_i) && (rs2_i != 5'd0))
      rs2_val = wb_data_i;
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{exm_wen_i, exm_rd_i, exm_data_i, wb_wen_i, wb_rd_i, wb_data_i,
                        rs1_i, rs2_i};
  assign rs1_val = rs1_data_i;
  assign rs2_val = rs2_data_i;
`endif

  // Handshake: flush > stall > capture. A flush or a capture with valid_i=0 clears
  // valid and every enable while the datapath holds; stall holds everything.
  logic            valid_q, valid_d;
  logic [XLEN-1:0] op1_q, op1_d, op2_q, op2_d, store_data_q, store_data_d, pc_q, pc_d;
  logic [3:0]      op_sel_q, op_sel_d;
  logic [4:0]      rd_q, rd_d;
  logic            reg_wen_q, reg_wen_d, mem_ren_q, mem_ren_d, mem_wen_q, mem_wen_d;
  logic            branch_q, branch_d, illegal_q, illegal_d;

  always_comb begin
    valid_d      = valid_q;
    op1_d        = op1_q;
    op2_d        = op2_q;
    store_data_d = store_data_q;
    pc_d         = pc_q;
    op_sel_d     = op_sel_q;
    rd_d         = rd_q;
    reg_wen_d    = reg_wen_q;
    mem_ren_d    = mem_ren_q;
    mem_wen_d    = mem_wen_q;
    branch_d     = branch_q;
    illegal_d    = illegal_q;
    if (flush_i || (!stall_i && !valid_i)) begin
      valid_d   = 1'b0;
      reg_wen_d = 1'b0;
      mem_ren_d = 1'b0;
      mem_wen_d = 1'b0;
      branch_d  = 1'b0;
      illegal_d = 1'b0;
    end else if (!stall_i) begin
      valid_d      = 1'b1;
      op1_d        = dec_zero_op1 ? '0 : rs1_val;
      op2_d        = dec_use_imm ? imm_i : rs2_val;
      store_data_d = rs2_val;
      pc_d         = pc_i;
      op_sel_d     = dec_op_sel;
      rd_d         = rd_i;
      reg_wen_d    = dec_reg_wen && (rd_i != 5'd0);
      mem_ren_d    = dec_mem_ren;
      mem_wen_d    = dec_mem_wen;
      branch_d     = dec_branch;
      illegal_d    = dec_illegal;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      valid_q      <= 1'b0;
      op1_q        <= '0;
      op2_q        <= '0;
      store_data_q <= '0;
      pc_q         <= '0;
      op_sel_q     <= 4'b0000;
      rd_q         <= 5'd0;
      reg_wen_q    <= 1'b0;
      mem_ren_q    <= 1'b0;
      mem_wen_q    <= 1'b0;
      branch_q     <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      op1_q        <= op1_d;
      op2_q        <= op2_d;
      store_data_q <= store_data_d;
      pc_q         <= pc_d;
      op_sel_q     <= op_sel_d;
      rd_q         <= rd_d;
      reg_wen_q    <= reg_wen_d;
      mem_ren_q    <= mem_ren_d;
      mem_wen_q    <= mem_wen_d;
      branch_q     <= branch_d;
      illegal_q    <= illegal_d;
    end
  end

  assign valid_o      = valid_q;
  assign op1_o        = op1_q;
  assign op2_o        = op2_q;
  assign store_data_o = store_data_q;
  assign pc_o         = pc_q;
  assign op_sel_o     = op_sel_q;
  assign rd_o         = rd_q;
  assign reg_wen_o    = reg_wen_q;
  assign mem_ren_o    = mem_ren_q;
  assign mem_wen_o    = mem_wen_q;
  assign branch_o     = branch_q;
  assign illegal_o    = illegal_q;

endmodule

// File: tb/tb_rv_id_ex_stage.sv
// Directed bench for rv_id_ex_stage; expectations follow RV_IDEX_FWD_EN when defined.
module tb_rv_id_ex_stage;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        valid_i, stall_i, flush_i;
  logic [63:0] pc_i;
  logic [6:0]  opcode_i;
  logic [2:0]  funct3_i;
  logic        funct7_5_i;
  logic [4:0]  rs1_i, rs2_i, rd_i;
  logic [63:0] rs1_data_i, rs2_data_i, imm_i;
  logic        exm_wen_i, wb_wen_i;
  logic [4:0]  exm_rd_i, wb_rd_i;
  logic [63:0] exm_data_i, wb_data_i;
  logic        valid_o;
  logic [63:0] op1_o, op2_o, store_data_o, pc_o;
  logic [3:0]  op_sel_o;
  logic [4:0]  rd_o;
  logic        reg_wen_o, mem_ren_o, mem_wen_o, branch_o, illegal_o;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_v;

  // clock/reset block
  always #5 clk_i = ~clk_i;

  rv_id_ex_stage #(.XLEN(64)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .valid_i(valid_i), .stall_i(stall_i), .flush_i(flush_i),
    .pc_i(pc_i), .opcode_i(opcode_i), .funct3_i(funct3_i), .funct7_5_i(funct7_5_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i), .rs1_data_i(rs1_data_i),
    .rs2_data_i(rs2_data_i), .imm_i(imm_i), .exm_wen_i(exm_wen_i), .exm_rd_i(exm_rd_i),
    .exm_data_i(exm_data_i), .wb_wen_i(wb_wen_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
    .valid_o(valid_o), .op1_o(op1_o), .op2_o(op2_o), .op_sel_o(op_sel_o),
    .store_data_o(store_data_o), .pc_o(pc_o), .rd_o(rd_o), .reg_wen_o(reg_wen_o),
    .mem_ren_o(mem_ren_o), .mem_wen_o(mem_wen_o), .branch_o(branch_o), .illegal_o(illegal_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // driver tasks
  task automatic instr(input logic [6:0] opc, input logic [2:0] f3, input logic f75,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                       input logic [63:0] d1, input logic [63:0] d2, input logic [63:0] imm,
                       input logic [63:0] pc);
    valid_i = 1'b1; opcode_i = opc; funct3_i = f3; funct7_5_i = f75;
    rs1_i = r1; rs2_i = r2; rd_i = rd; rs1_data_i = d1; rs2_data_i = d2;
    imm_i = imm; pc_i = pc;
  endtask

  task automatic fwd(input logic ew, input logic [4:0] er, input logic [63:0] ed,
                     input logic ww, input logic [4:0] wr, input logic [63:0] wd);
    exm_wen_i = ew; exm_rd_i = er; exm_data_i = ed;
    wb_wen_i = ww; wb_rd_i = wr; wb_data_i = wd;
  endtask

  task automatic randomize_inputs();
    valid_i = 1'($urandom_range(1)); stall_i = 1'($urandom_range(1));
    flush_i = 1'($urandom_range(1));
    pc_i = {$urandom, $urandom}; opcode_i = 7'($urandom_range(127));
    funct3_i = 3'($urandom_range(7)); funct7_5_i = 1'($urandom_range(1));
    rs1_i = 5'($urandom_range(31)); rs2_i = 5'($urandom_range(31)); rd_i = 5'($urandom_range(31));
    rs1_data_i = {$urandom, $urandom}; rs2_data_i = {$urandom, $urandom};
    imm_i = {$urandom, $urandom};
    fwd(1'($urandom_range(1)), 5'($urandom_range(31)), {$urandom, $urandom},
        1'($urandom_range(1)), 5'($urandom_range(31)), {$urandom, $urandom});
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 64'(valid_o), 64'd0);
    chk({tag, "_op1"}, op1_o, 64'd0);
    chk({tag, "_op2"}, op2_o, 64'd0);
    chk({tag, "_opsel"}, 64'(op_sel_o), 64'd0);
    chk({tag, "_sdata"}, store_data_o, 64'd0);
    chk({tag, "_pc"}, pc_o, 64'd0);
    chk({tag, "_rd"}, 64'(rd_o), 64'd0);
    chk({tag, "_en"}, 64'({reg_wen_o, mem_ren_o, mem_wen_o, branch_o, illegal_o}), 64'd0);
  endtask

  initial begin
    // reset with random inputs
    rstn_i = 1'b0;
    randomize_inputs();
    repeat (3) begin
      tick();
      randomize_inputs();
    end
    chk_all_zero("reset");
    // release with valid_i=0
    valid_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    rstn_i = 1'b1;
    tick(); tick();
    chk_all_zero("idle");

    // R-type SUB
    fwd(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    instr(7'b0110011, 3'b000, 1'b1, 5'd1, 5'd2, 5'd3, 64'd10, 64'd3, 64'hdead, 64'h100);
    tick();
    chk("sub_opsel", 64'(op_sel_o), 64'h6);
    chk("sub_op1", op1_o, 64'd10);
    chk("sub_op2", op2_o, 64'd3);
    chk("sub_wen", 64'(reg_wen_o), 64'd1);
    chk("sub_valid", 64'(valid_o), 64'd1);
    chk("sub_rd", 64'(rd_o), 64'd3);
    chk("sub_pc", pc_o, 64'h100);
    chk("sub_mem", 64'({mem_ren_o, mem_wen_o, branch_o, illegal_o}), 64'd0);

    // forwarding: both sources match rs1=5, EX/MEM wins
    instr(7'b0110011, 3'b000, 1'b0, 5'd5, 5'd6, 5'd7, 64'h11, 64'h22, 64'd0, 64'h104);
    fwd(1'b1, 5'd5, 64'hAA, 1'b1, 5'd5, 64'hBB);
    tick();
`ifdef RV_IDEX_FWD_EN
    exp_v = 64'hAA;
`else
    exp_v = 64'h11;
`endif
    chk("fwd_exm_op1", op1_o, exp_v);
    chk("fwd_add_opsel", 64'(op_sel_o), 64'h2);
    chk("fwd_op2", op2_o, 64'h22);
    // only MEM/WB matches rs1; EX/MEM matches rs2
    fwd(1'b1, 5'd6, 64'hCC, 1'b1, 5'd5, 64'hBB);
    tick();
`ifdef RV_IDEX_FWD_EN
    exp_v = 64'hBB;
`else
    exp_v = 64'h11;
`endif
    chk("fwd_wb_op1", op1_o, exp_v);
`ifdef RV_IDEX_FWD_EN
    exp_v = 64'hCC;
`else
    exp_v = 64'h22;
`endif
    chk("fwd_exm_op2", op2_o, exp_v);
    chk("fwd_sdata", store_data_o, exp_v);
    // x0 is never forwarded
    instr(7'b0110011, 3'b000, 1'b0, 5'd0, 5'd6, 5'd7, 64'h33, 64'h22, 64'd0, 64'h108);
    fwd(1'b1, 5'd0, 64'hAA, 1'b1, 5'd0, 64'hBB);
    tick();
    chk("fwd_x0_op1", op1_o, 64'h33);
    fwd(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);

    // store
    instr(7'b0100011, 3'b011, 1'b0, 5'd2, 5'd4, 5'd9, 64'h1000, 64'h55, 64'd8, 64'h10c);
    tick();
    chk("st_opsel", 64'(op_sel_o), 64'h2);
    chk("st_op1", op1_o, 64'h1000);
    chk("st_op2", op2_o, 64'd8);
    chk("st_sdata", store_data_o, 64'h55);
    chk("st_memwen", 64'(mem_wen_o), 64'd1);
    chk("st_regwen", 64'(reg_wen_o), 64'd0);

    // stall for 3 cycles with changing inputs
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      instr(7'b0110011, 3'b111, 1'b0, 5'(i + 1), 5'd3, 5'd12, {$urandom, $urandom},
            {$urandom, $urandom}, 64'd0, 64'(i + 64'h200));
      tick();
      chk("stall_op1", op1_o, 64'h1000);
      chk("stall_op2", op2_o, 64'd8);
      chk("stall_opsel", 64'(op_sel_o), 64'h2);
      chk("stall_pc", pc_o, 64'h10c);
      chk("stall_ctl", 64'({valid_o, reg_wen_o, mem_wen_o}), 64'b101);
    end
    // flush beats stall
    flush_i = 1'b1;
    tick();
    chk("flush_valid", 64'(valid_o), 64'd0);
    chk("flush_regwen", 64'(reg_wen_o), 64'd0);
    chk("flush_memwen", 64'(mem_wen_o), 64'd0);
    stall_i = 1'b0; flush_i = 1'b0;

    // load
    instr(7'b0000011, 3'b011, 1'b1, 5'd2, 5'd4, 5'd10, 64'h2000, 64'h77, 64'h10, 64'h300);
    tick();
    chk("ld_opsel", 64'(op_sel_o), 64'h2);
    chk("ld_op2", op2_o, 64'h10);
    chk("ld_en", 64'({reg_wen_o, mem_ren_o, mem_wen_o}), 64'b110);

    // LUI
    instr(7'b0110111, 3'b101, 1'b0, 5'd8, 5'd4, 5'd11, 64'h999, 64'h77, 64'h12345000, 64'h304);
    tick();
    chk("lui_op1", op1_o, 64'd0);
    chk("lui_op2", op2_o, 64'h12345000);
    chk("lui_regwen", 64'(reg_wen_o), 64'd1);

    // illegal opcode
    instr(7'b1111111, 3'b000, 1'b0, 5'd1, 5'd2, 5'd13, 64'h1, 64'h2, 64'h3, 64'h308);
    tick();
    chk("ill_opsel", 64'(op_sel_o), 64'hF);
    chk("ill_flag", 64'(illegal_o), 64'd1);
    chk("ill_en", 64'({reg_wen_o, mem_ren_o, mem_wen_o, branch_o}), 64'd0);

    // BEQ and a non-BEQ branch funct3
    instr(7'b1100011, 3'b000, 1'b0, 5'd1, 5'd2, 5'd14, 64'h40, 64'h41, 64'h80, 64'h30c);
    tick();
    chk("beq_opsel", 64'(op_sel_o), 64'h6);
    chk("beq_op2", op2_o, 64'h41);
    chk("beq_en", 64'({branch_o, reg_wen_o, illegal_o}), 64'b100);
    instr(7'b1100011, 3'b001, 1'b0, 5'd1, 5'd2, 5'd14, 64'h40, 64'h41, 64'h80, 64'h310);
    tick();
    chk("bne_ill", 64'({illegal_o, branch_o}), 64'b10);
    chk("bne_opsel", 64'(op_sel_o), 64'hF);

    // R-type with bad funct3, I-type ignores bit30, OR, rd=0
    instr(7'b0110011, 3'b001, 1'b0, 5'd1, 5'd2, 5'd3, 64'h5, 64'h6, 64'h7, 64'h314);
    tick();
    chk("rbad_ill", 64'({illegal_o, reg_wen_o}), 64'b10);
    instr(7'b0010011, 3'b000, 1'b1, 5'd1, 5'd2, 5'd3, 64'h5, 64'h6, 64'h7, 64'h318);
    tick();
    chk("iadd_opsel", 64'(op_sel_o), 64'h2);
    chk("iadd_op2", op2_o, 64'h7);
    instr(7'b0110011, 3'b110, 1'b0, 5'd1, 5'd2, 5'd0, 64'h5, 64'h6, 64'h7, 64'h31c);
    tick();
    chk("or_opsel", 64'(op_sel_o), 64'h1);
    chk("rd0_regwen", 64'(reg_wen_o), 64'd0);
    instr(7'b0010011, 3'b111, 1'b0, 5'd1, 5'd2, 5'd4, 64'h5, 64'h6, 64'h7, 64'h320);
    tick();
    chk("andi_opsel", 64'(op_sel_o), 64'h0);
    chk("andi_valid", 64'({valid_o, reg_wen_o}), 64'b11);

    // reset asserted mid-stall clears immediately
    stall_i = 1'b1;
    tick();
    #2 rstn_i = 1'b0;
    #1;
    chk_all_zero("rst_stall");
    tick();
    #1 rstn_i = 1'b1;
    stall_i = 1'b0;
    instr(7'b0110011, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 64'h9, 64'h1, 64'd0, 64'h400);
    tick();
    chk("post_rst_op1", op1_o, 64'h9);
    chk("post_rst_valid", 64'(valid_o), 64'd1);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv_id_ex_stage.md
# rv_id_ex_stage

ID/EX pipeline stage of the RV64 core, directly upstream of the ALU. It decodes the instruction fields from ID into the 4-bit ALU operation select, picks operand 2 (register or immediate), and applies optional EX/MEM and MEM/WB forwarding. The result is registered into the EX-stage operand and control set, with stall and flush handshakes. Its outputs `op1_o`, `op2_o` and `op_sel_o` drive the ALU's `op1_i`, `op2_i` and `op_sel_i`.

## Interface
Parameters:
- XLEN, 64, data width. The ALU is fixed at 64, so only 64 is supported.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge. Reset is asynchronous and active-low.
- rstn_i  in  1  asynchronous active-low reset.
- valid_i  in  1  ID holds a valid instruction.
- stall_i  in  1  hold all EX-stage registers.
- flush_i  in  1  insert a bubble.
- pc_i  in  64  instruction PC.
- opcode_i  in  7  instruction opcode.
- funct3_i  in  3  instruction funct3.
- funct7_5_i  in  1  instruction bit 30.
- rs1_i, rs2_i, rd_i  in  5 each  register indices.
- rs1_data_i, rs2_data_i  in  64 each  register-file read data.
- imm_i  in  64  sign-extended immediate.
- exm_wen_i  in  1  EX/MEM forwarding source: write enable.
- exm_rd_i  in  5  EX/MEM forwarding source: destination register.
- exm_data_i  in  64  EX/MEM forwarding source: data.
- wb_wen_i  in  1  MEM/WB forwarding source: write enable.
- wb_rd_i  in  5  MEM/WB forwarding source: destination register.
- wb_data_i  in  64  MEM/WB forwarding source: data.
- valid_o  out  1  EX-stage instruction valid.
- op1_o, op2_o  out  64 each  ALU operands.
- op_sel_o  out  4  ALU operation select.
- store_data_o  out  64  forwarded rs2 value, for stores.
- pc_o  out  64  registered PC.
- rd_o  out  5  registered destination register.
- reg_wen_o  out  1  register write enable.
- mem_ren_o  out  1  memory read enable.
- mem_wen_o  out  1  memory write enable.
- branch_o  out  1  BEQ; EX uses the ALU zero flag.
- illegal_o  out  1  unsupported instruction.

## Operation
- ALU operation codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1111 pass op1.
- Decode by opcode:
  - 0110011 (R-type): funct3 000 gives ADD when bit30=0 and SUB when bit30=1; 111 gives AND; 110 gives OR. op2 = rs2, reg_wen=1.
  - 0010011 (I-type): funct3 000 ADD, 111 AND, 110 OR; op2 = imm, reg_wen=1. Bit30 is ignored.
  - 0000011 (load): ADD, op2 = imm, mem_ren=1, reg_wen=1.
  - 0100011 (store): ADD, op2 = imm, mem_wen=1.
  - 1100011 with funct3 000 (BEQ): SUB, op2 = rs2, branch=1.
  - 0110111 (LUI): ADD, op1 = 0, op2 = imm, reg_wen=1.
  - Anything else, including other funct3 values: op_sel 1111, illegal=1, and all enables 0.
- Forwarding, per source operand, when enabled (see Configuration):
  - Use exm_data_i if exm_wen_i and exm_rd_i == rs and rs != 0.
  - Otherwise use wb_data_i under the same rule for the MEM/WB source.
  - Otherwise use the register-file data.
  - EX/MEM has priority over MEM/WB.
- Forwarding applies to op1, to op2 when it comes from rs2, and to store_data.
- rd_o is registered as rd_i. reg_wen_o is forced to 0 when rd_i == 0.

## Timing
- Latency is 1 cycle: ID inputs sampled at edge N appear on the outputs after edge N.
- Update priority at each edge:
  - Flush first: valid_o and all enables (reg_wen, mem_ren, mem_wen, branch, illegal) go to 0. The datapath registers may hold any value.
  - Then stall: every output holds its value.
  - Then capture: if valid_i=0, a bubble is captured (same as flush); otherwise the decoded values are captured.
- Flush takes precedence over a simultaneous stall.
- Reset clears every output to 0: op_sel_o=0000, operands 0, pc 0, rd 0, all enables and valid 0.
- Reset asserted mid-stall clears the stage immediately; the first capture happens on the first edge after rstn_i rises.
- All decode and forwarding logic is combinational ahead of the registers. There is no combinational path from any input to any output.

## Configuration
- Macro `RV_IDEX_FWD_EN`.
- Defined: forwarding muxes are present as described in Operation.
- Undefined: op1, op2 and store_data take rs1_data_i and rs2_data_i directly. The exm_* and wb_* inputs are unused, and hazards are resolved by stalls.

## Test plan
- Reset: hold rstn_i=0 with random inputs → every output 0. After release with valid_i=0, outputs stay 0.
- R-type SUB: rs1_data=10, rs2_data=3, funct3=000, bit30=1 → one cycle later op_sel_o=0110, op1_o=10, op2_o=3, reg_wen_o=1, valid_o=1.
- Forwarding (macro defined): exm_wen=1 with exm_rd=rs1=5 and exm_data=0xAA, and wb_wen=1 with wb_rd=5 and wb_data=0xBB → op1_o=0xAA. Repeat with exm_rd=0 and rs1=0 → op1_o=rs1_data_i.
- Stall and flush: stall_i=1 for 3 cycles while inputs change → outputs unchanged. Then stall_i=1 and flush_i=1 together → valid_o=0, reg_wen_o=0, mem_wen_o=0.
- Store, LUI, illegal: store with imm=8 → op_sel 0010, op2 = 8, mem_wen=1, reg_wen=0. LUI with imm=0x12345000 → op1_o=0, op2_o=0x12345000. opcode 1111111 → op_sel 1111, illegal_o=1, all enables 0.
- Macro undefined: the forwarding scenario above → op1_o equals rs1_data_i.
